dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_pick.sv | 44 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, requester IDs, default burst limit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-input round-robin pick with a burst cap on the current owner.
// Latency: purely combinational.
// Backpressure: the loser is simply not picked; it retries next cycle.
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int CW        = $clog2(BURST_MAX + 1)
) (
    input  state_t          state,
    input  logic            last_gnt,
    input  logic [CW-1:0]   burst_cnt,
    input  logic            c_req,
    input  logic            d_req,
    output logic            pick_c,
    output logic            pick_d
);

    always_comb begin
        pick_c = 1'b0;
        pick_d = 1'b0;
        if (c_req && d_req) begin
            case (state)
                OWN_C: begin
                    if (burst_cnt < CW'(BURST_MAX)) pick_c = 1'b1;
                    else                            pick_d = 1'b1;
                end
                OWN_D: begin
                    if (burst_cnt < CW'(BURST_MAX)) pick_d = 1'b1;
                    else                            pick_c = 1'b1;
                end
                default: begin
                    // From IDLE, whoever did not win last time goes first.
                    if (last_gnt == REQ_DBG) pick_c = 1'b1;
                    else                     pick_d = 1'b1;
                end
            endcase
        end else begin
            pick_c = c_req;
            pick_d = d_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and debug/DMA ports onto one single-cycle data memory.
// Latency: grant and memory access same cycle; read data one cycle later.
// Backpressure: losing core sees c_stall; losing debug port just sees no d_gnt.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wd,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rd,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wd,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int CW = $clog2(BURST_MAX + 1);

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          c_rvalid_q, d_rvalid_q;
    logic [DW-1:0] c_rd_q, d_rd_q;
    logic          pick_c, pick_d;

    rr_pick #(
        .BURST_MAX (BURST_MAX),
        .CW        (CW)
    ) u_rr_pick (
        .state     (state_q),
        .last_gnt  (last_gnt_q),
        .burst_cnt (burst_q),
        .c_req     (c_req),
        .d_req     (d_req),
        .pick_c    (pick_c),
        .pick_d    (pick_d)
    );

    // Reset masks the grants combinationally so nothing reaches memory while rst is high.
    assign c_gnt   = pick_c & ~rst;
    assign d_gnt   = pick_d & ~rst;
    assign c_stall = c_req & ~c_gnt & ~rst;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (c_gnt) begin
            mem_we   = c_we;
            mem_addr = c_addr;
            mem_wd   = c_wd;
        end else if (d_gnt) begin
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_wd   = d_wd;
        end
    end

    always_comb begin
        state_d    = IDLE;
        last_gnt_d = last_gnt_q;
        burst_d    = burst_q;
        if (c_gnt) begin
            state_d    = OWN_C;
            last_gnt_d = REQ_CORE;
            if (state_q != OWN_C)                 burst_d = CW'(1);
            else if (burst_q != CW'(BURST_MAX))   burst_d = burst_q + CW'(1);
        end else if (d_gnt) begin
            state_d    = OWN_D;
            last_gnt_d = REQ_DBG;
            if (state_q != OWN_D)                 burst_d = CW'(1);
            else if (burst_q != CW'(BURST_MAX))   burst_d = burst_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= REQ_DBG;
            burst_q    <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rd_q     <= '0;
            d_rd_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            burst_q    <= burst_d;
            c_rvalid_q <= c_gnt & ~c_we;
            d_rvalid_q <= d_gnt & ~d_we;
            if (c_gnt && !c_we) c_rd_q <= mem_rd;
            if (d_gnt && !d_we) d_rd_q <= mem_rd;
        end
    end

    // A read result landing in a reset cycle is suppressed rather than delivered.
    assign c_rvalid = c_rvalid_q & ~rst;
    assign d_rvalid = d_rvalid_q & ~rst;
    assign c_rd     = rst ? '0 : c_rd_q;
    assign d_rd     = rst ? '0 : d_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random + directed bench for dmem_arbiter against a grant-history model.
module tb_dmem_arbiter;

    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rd, d_rd;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(BMAX)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rd(c_rd),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd(d_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    function automatic bit [31:0] init_val(int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return (32'h01010101 * idx) ^ 32'hA5A50000;
    endfunction

    // Memory environment: 16 words, combinational read.
    bit [31:0] mem [16];
    bit [15:0] mem_flag;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[5:2]]      <= mem_wd;
            mem_flag[mem_addr[5:2]] <= 1'b1;
        end
    end
    assign mem_rd = mem_flag[mem_addr[5:2]] ? mem[mem_addr[5:2]] : init_val(int'(mem_addr[5:2]));

    typedef struct {
        bit        c_gnt, d_gnt, c_stall, mem_we, c_rvalid, d_rvalid;
        bit [31:0] mem_addr, mem_wd, c_rd, d_rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("c_gnt",    32'(c_gnt),    32'(e.c_gnt));
            chk("d_gnt",    32'(d_gnt),    32'(e.d_gnt));
            chk("c_stall",  32'(c_stall),  32'(e.c_stall));
            chk("mem_we",   32'(mem_we),   32'(e.mem_we));
            chk("mem_addr", mem_addr,      e.mem_addr);
            chk("mem_wd",   mem_wd,        e.mem_wd);
            chk("c_rvalid", 32'(c_rvalid), 32'(e.c_rvalid));
            chk("d_rvalid", 32'(d_rvalid), 32'(e.d_rvalid));
            chk("c_rd",     c_rd,          e.c_rd);
            chk("d_rd",     d_rd,          e.d_rd);
        end
    end

    // Reference model: who was granted last cycle, how long the current streak is,
    // which side won the most recent grant, plus a shadow memory.
    int        prev_win = 0;   // 0 none, 1 core, 2 debug
    int        streak   = 0;
    int        last_win = 2;
    bit        pend_crv = 0, pend_drv = 0;
    bit [31:0] m_crd = 0, m_drd = 0;
    bit [31:0] mm [16];
    bit [15:0] mm_flag = 0;

    function automatic bit [31:0] mm_read(bit [31:0] a);
        return mm_flag[a[5:2]] ? mm[a[5:2]] : init_val(int'(a[5:2]));
    endfunction

    task automatic step(bit r, bit cq, bit cw, bit [31:0] ca, bit [31:0] cd,
                        bit dq, bit dw, bit [31:0] da, bit [31:0] dd, output int win);
        exp_t e;
        rst = r; c_req = cq; c_we = cw; c_addr = ca; c_wd = cd;
        d_req = dq; d_we = dw; d_addr = da; d_wd = dd;
        win = 0;
        if (!r) begin
            if (cq && dq) begin
                if (prev_win == 0)     win = (last_win == 2) ? 1 : 2;
                else if (streak < BMAX) win = prev_win;
                else                   win = 3 - prev_win;
            end else if (cq) win = 1;
            else if (dq)     win = 2;
        end
        e.c_gnt    = (win == 1);
        e.d_gnt    = (win == 2);
        e.c_stall  = cq && !r && win != 1;
        e.mem_we   = (win == 1) ? cw : (win == 2) ? dw : 1'b0;
        e.mem_addr = (win == 1) ? ca : (win == 2) ? da : 32'h0;
        e.mem_wd   = (win == 1) ? cd : (win == 2) ? dd : 32'h0;
        e.c_rvalid = pend_crv && !r;
        e.d_rvalid = pend_drv && !r;
        e.c_rd     = r ? 32'h0 : m_crd;
        e.d_rd     = r ? 32'h0 : m_drd;
        exp_q.push_back(e);

        if (r) begin
            prev_win = 0; streak = 0; last_win = 2;
            pend_crv = 0; pend_drv = 0; m_crd = 0; m_drd = 0;
        end else begin
            pend_crv = (win == 1) && !cw;
            pend_drv = (win == 2) && !dw;
            if (pend_crv) m_crd = mm_read(ca);
            if (pend_drv) m_drd = mm_read(da);
            if (win == 1 && cw) begin mm[ca[5:2]] = cd; mm_flag[ca[5:2]] = 1'b1; end
            if (win == 2 && dw) begin mm[da[5:2]] = dd; mm_flag[da[5:2]] = 1'b1; end
            if (win != 0) begin
                streak   = (win == prev_win) ? ((streak < BMAX) ? streak + 1 : BMAX) : 1;
                last_win = win;
            end
            prev_win = win;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int        w;
        int        seq_ok;
        bit        cp, dp, cwr, dwr;
        bit [31:0] ca, cdat, da, ddat;
        string     exp_seq, got_seq;

        rst = 1'b1; c_req = 0; c_we = 0; c_addr = 0; c_wd = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
        @(posedge clk); #1;
        step(1, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0, w);   // reset masks requests
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Core-only read of 0x10, then a quiet cycle for the rvalid.
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Contention straight after reset, held for 10 cycles.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, w);
        exp_seq = "CCCCDDDDCC";
        got_seq = "";
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 32'h0, 0, 1, 0, 32'h4, 0, w);
            got_seq = {got_seq, (w == 1) ? "C" : "D"};
        end
        n_tests++;
        if (got_seq != exp_seq) begin
            n_fail++;
            $display("FAIL burst_model_seq: got %s expected %s", got_seq, exp_seq);
        end

        // Idle period, then debug write, then reading it back.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, w);
        step(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, w);
        step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, w);
        step(0, 1, 0, 32'h24, 0, 0, 0, 0, 0, w);   // back-to-back reads

        // Reset the cycle after a granted read.
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, w);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, w);
        step(0, 1, 0, 32'h8, 0, 1, 0, 32'hC, 0, w);  // IDLE again: core wins
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, w);

        // Random traffic; each side holds its transaction until the model grants it.
        cp = 0; dp = 0; cwr = 0; dwr = 0; ca = 0; da = 0; cdat = 0; ddat = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1; cwr = $urandom_range(0, 2) == 0;
                ca = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; cdat = $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; dwr = $urandom_range(0, 1) == 0;
                da = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; ddat = $urandom;
            end
            if ($urandom_range(0, 79) == 0) begin
                step(1, cp, cwr, ca, cdat, dp, dwr, da, ddat, w);
            end else begin
                step(0, cp, cwr, ca, cdat, dp, dwr, da, ddat, w);
                if (w == 1) cp = 0;
                if (w == 2) dp = 0;
            end
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
